// File: rtl/rst_seq.sv
// Reset sequencer for the divider's write and read clock paths.
// After power-up it holds both resets, releases write first, then read after a
// stagger. A synchronized soft-reset rise re-runs the whole sequence, and a
// synchronized read-restart rise pulses only the read reset while in RUN.
module rst_seq #(
  parameter int HOLD_CYC    = 8,
  parameter int STAGGER_CYC = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst_req,
  input  logic       r_restart_req,
  output logic       w_rst,
  output logic       r_rst,
  output logic       ready,
  output logic [1:0] state_o,
  output logic [7:0] soft_cnt
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_W_REL   = 2'd1,
    ST_RUN     = 2'd2,
    ST_R_PULSE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] soft_sync_q;
  logic [SYNC_STAGES-1:0] rr_sync_q;
  logic                   soft_ed_q;
  logic                   rr_ed_q;
  logic                   soft_rise_s;
  logic                   rr_rise_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             soft_cnt_q, soft_cnt_d;
  logic                   w_rst_q, r_rst_q, ready_q;

  // Synchronize both async request levels and keep one delayed copy for rise detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      soft_sync_q <= '0;
      rr_sync_q   <= '0;
      soft_ed_q   <= 1'b0;
      rr_ed_q     <= 1'b0;
    end else begin
      soft_sync_q <= {soft_sync_q[SYNC_STAGES-2:0], soft_rst_req};
      rr_sync_q   <= {rr_sync_q[SYNC_STAGES-2:0], r_restart_req};
      soft_ed_q   <= soft_sync_q[SYNC_STAGES-1];
      rr_ed_q     <= rr_sync_q[SYNC_STAGES-1];
    end
  end

  assign soft_rise_s = soft_sync_q[SYNC_STAGES-1] & ~soft_ed_q;
  assign rr_rise_s   = rr_sync_q[SYNC_STAGES-1] & ~rr_ed_q;

  // Next-state logic: a soft rise overrides everything, read restarts only count in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    soft_cnt_d = soft_cnt_q;
    if (soft_rise_s) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      if (soft_cnt_q != 8'hFF) begin
        soft_cnt_d = soft_cnt_q + 8'd1;
      end else begin
        soft_cnt_d = soft_cnt_q;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_W_REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_W_REL: begin
          if (cnt_q == STAG_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (rr_rise_s) begin
            state_d = ST_R_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_R_PULSE: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they change with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      soft_cnt_q <= 8'd0;
      w_rst_q    <= 1'b1;
      r_rst_q    <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      soft_cnt_q <= soft_cnt_d;
      w_rst_q    <= (state_d == ST_HOLD);
      r_rst_q    <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
    end
  end

  assign w_rst    = w_rst_q;
  assign r_rst    = r_rst_q;
  assign ready    = ready_q;
  assign state_o  = state_q;
  assign soft_cnt = soft_cnt_q;

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Reset sequencer that drives the w_rst and r_rst inputs of the clock divider from a single clk domain.
- Holds both divided-clock domains in reset after power-up.
- Releases the write domain first, then the read domain after a programmable stagger.
- Re-sequences on a synchronized soft-reset request, and can pulse the read domain alone.
- Sits directly upstream of the divider. Its ready output gates downstream FIFO traffic.

Parameters:
HOLD_CYC, 8, clk cycles both resets stay asserted in HOLD; also the r_rst pulse length in R_PULSE (legal range 2..2^CNT_W-1)
STAGGER_CYC, 3, clk cycles between w_rst release and r_rst release (legal range 1..2^CNT_W-1)
SYNC_STAGES, 2, flop stages synchronizing each async request input (legal minimum 2)
CNT_W, 8, width of the internal cycle counter

Ports:
clk  input  1  system clock, same clock as the divider
rst  input  1  asynchronous active-low reset
soft_rst_req  input  1  async level request; a rising edge re-sequences both domains
r_restart_req  input  1  async level request; a rising edge pulses r_rst only
w_rst  output  1  active-high reset to the divider's write-clock path
r_rst  output  1  active-high reset to the divider's read-clock path
ready  output  1  high only when both domains are out of reset and stable
state_o  output  2  current state (HOLD=0, W_REL=1, RUN=2, R_PULSE=3)
soft_cnt  output  8  saturating count of accepted soft resets

Behaviour:
- rst=0, asynchronously:
  - state=HOLD, cnt=0, all sync flops and edge-detect flops=0.
  - w_rst=1, r_rst=1, ready=0, soft_cnt=0.
- All outputs are registered. They take the decode of the next state on the same edge as the state change.
- Request synchronization:
  - Each request passes through a SYNC_STAGES flop chain, then one edge-detect flop.
  - A rise is detected when the last sync flop=1 and the edge-detect flop=0.
  - With SYNC_STAGES=2, a request first sampled high at edge k acts at edge k+2.
- HOLD (w_rst=1, r_rst=1, ready=0):
  - cnt increments each cycle.
  - At cnt==HOLD_CYC-1: go to W_REL, cnt<=0.
- W_REL (w_rst=0, r_rst=1, ready=0):
  - cnt increments each cycle.
  - At cnt==STAGGER_CYC-1: go to RUN, cnt<=0.
- RUN (w_rst=0, r_rst=0, ready=1):
  - Remains until a request rise.
- R_PULSE (w_rst=0, r_rst=1, ready=0):
  - cnt increments each cycle.
  - At cnt==HOLD_CYC-1: go to RUN, cnt<=0.
- Soft-rise in any state:
  - Go to HOLD, cnt<=0.
  - soft_cnt increments, saturating at 255.
  - A soft-rise while already in HOLD restarts the hold count.
- r_restart rise:
  - Honoured only in RUN: go to R_PULSE, cnt<=0.
  - Ignored (not queued) in HOLD, W_REL and R_PULSE.
- Simultaneous soft-rise and r_restart rise: soft wins, and the r_restart rise is discarded.
- Level-held requests act once per rising edge. A request held high causes no repeat action.
- Power-up timing, HOLD_CYC=8, STAGGER_CYC=3 (edges counted after rst deasserts):
  - w_rst falls at edge 8.
  - r_rst falls and ready rises at edge 11.
- Invariant: whenever r_rst=0, w_rst=0. ready == (w_rst==0 && r_rst==0).
- Asserting rst mid-sequence returns to the reset values immediately, without waiting for clk.

Test Plan:
1. Power-up, defaults: release rst, hold requests low -> w_rst 1→0 at edge 8; r_rst 1→0 and ready 0→1 at edge 11; state_o 0→1→2.
2. Soft reset in RUN: raise soft_rst_req at edge k -> w_rst=r_rst=1, ready=0 at edge k+2; soft_cnt=1; full sequence repeats (w_rst low 8 edges later, r_rst 3 edges after that).
3. Read-only restart: r_restart_req rise in RUN -> only r_rst high for 8 cycles; w_rst stays 0; ready=0 during pulse; back to RUN, ready=1.
4. Collisions: both requests rise on the same edge in RUN -> HOLD entered, no R_PULSE afterwards. Soft rise at HOLD cnt=5 -> hold restarts, w_rst falls 8 edges later. r_restart during W_REL -> ignored.
5. Mid-sequence async reset: pull rst low during W_REL between clk edges -> w_rst=1, r_rst=1, ready=0, soft_cnt=0 immediately; re-release repeats scenario 1.
6. Saturation and level-hold: 260 soft-reset pulses -> soft_cnt stops at 255. Hold soft_rst_req high for 50 cycles -> exactly one re-sequence.
